// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter: default widths
// and the round-robin priority state.
package regfile_wb_arbiter_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned REG_CNT_DEF = 32;
  localparam int unsigned REG_AW      = $clog2(REG_CNT_DEF);

  typedef enum logic [0:0] {
    PRIO0 = 1'b0,
    PRIO1 = 1'b1
  } prio_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue,
// cleared on the register-file write edge, with two combinational lookups.
module regfile_scoreboard #(
  parameter int unsigned REG_CNT = 32,
  parameter int unsigned AW      = $clog2(REG_CNT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en_i,
  input  logic [AW-1:0] set_idx_i,
  input  logic          clr_en_i,
  input  logic [AW-1:0] clr_idx_i,
  input  logic [AW-1:0] rs1_i,
  input  logic [AW-1:0] rs2_i,
  output logic          rs1_pend_o,
  output logic          rs2_pend_o
);

  logic [REG_CNT-1:0] pend_q;
  logic [REG_CNT-1:0] pend_d;

  // Set is applied after clear so a same-edge set/clear leaves the bit set;
  // x0 is never marked pending.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < int'(REG_CNT); i++) begin
      pend_d[i] = (pend_q[i] & ~(clr_en_i & (clr_idx_i == AW'(i))))
                | (set_en_i & (set_idx_i == AW'(i)) & (set_idx_i != {AW{1'b0}}));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= {REG_CNT{1'b0}};
    end else begin
      pend_q <= pend_d;
    end
  end

  assign rs1_pend_o = (rs1_i != {AW{1'b0}}) & pend_q[rs1_i];
  assign rs2_pend_o = (rs2_i != {AW{1'b0}}) & pend_q[rs2_i];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester round-robin write-back arbiter driving a registered register-file
// write port, plus busy tracking. WB_BYPASS_EN adds same-cycle forwarding outputs.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned REG_CNT = REG_CNT_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue_valid,
  input  logic [$clog2(REG_CNT)-1:0] issue_rd,
  input  logic                       wb0_valid,
  input  logic [$clog2(REG_CNT)-1:0] wb0_rd,
  input  logic [XLEN-1:0]            wb0_data,
  output logic                       wb0_ready,
  input  logic                       wb1_valid,
  input  logic [$clog2(REG_CNT)-1:0] wb1_rd,
  input  logic [XLEN-1:0]            wb1_data,
  output logic                       wb1_ready,
  output logic [$clog2(REG_CNT)-1:0] a3,
  output logic [XLEN-1:0]            di3,
  output logic                       we3,
  input  logic [$clog2(REG_CNT)-1:0] rs1,
  input  logic [$clog2(REG_CNT)-1:0] rs2,
  output logic                       rs1_busy,
  output logic                       rs2_busy
`ifdef WB_BYPASS_EN
  ,
  output logic                       rs1_fwd,
  output logic                       rs2_fwd,
  output logic [XLEN-1:0]            fwd_data
`endif
);

  localparam int unsigned AW = $clog2(REG_CNT);

  prio_e           prio_q, prio_d;
  logic            gnt0_s, gnt1_s;
  logic [AW-1:0]   a3_q, a3_d;
  logic [XLEN-1:0] di3_q, di3_d;
  logic            we3_q, we3_d;
  logic            rs1_pend_s, rs2_pend_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= PRIO0;
    end else begin
      prio_q <= prio_d;
    end
  end

  // The winner hands tie priority to the other requester.
  always_comb begin
    prio_d = prio_q;
    case (prio_q)
      PRIO0:   if (gnt0_s) prio_d = PRIO1; else prio_d = PRIO0;
      PRIO1:   if (gnt1_s) prio_d = PRIO0; else prio_d = PRIO1;
      default: prio_d = PRIO0;
    endcase
  end

  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (reset) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case (prio_q)
        PRIO0: begin
          gnt0_s = wb0_valid;
          gnt1_s = wb1_valid & ~wb0_valid;
        end
        PRIO1: begin
          gnt1_s = wb1_valid;
          gnt0_s = wb0_valid & ~wb1_valid;
        end
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end
  end

  assign wb0_ready = gnt0_s;
  assign wb1_ready = gnt1_s;

  // Writes to x0 are accepted and latched but never strobe the write enable.
  always_comb begin
    a3_d  = a3_q;
    di3_d = di3_q;
    we3_d = 1'b0;
    if (gnt0_s) begin
      a3_d  = wb0_rd;
      di3_d = wb0_data;
      we3_d = (wb0_rd != {AW{1'b0}});
    end else if (gnt1_s) begin
      a3_d  = wb1_rd;
      di3_d = wb1_data;
      we3_d = (wb1_rd != {AW{1'b0}});
    end else begin
      we3_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a3_q  <= {AW{1'b0}};
      di3_q <= {XLEN{1'b0}};
      we3_q <= 1'b0;
    end else begin
      a3_q  <= a3_d;
      di3_q <= di3_d;
      we3_q <= we3_d;
    end
  end

  assign a3  = a3_q;
  assign di3 = di3_q;
  assign we3 = we3_q;

  regfile_scoreboard #(
    .REG_CNT (REG_CNT),
    .AW      (AW)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .set_en_i   (issue_valid),
    .set_idx_i  (issue_rd),
    .clr_en_i   (we3_q),
    .clr_idx_i  (a3_q),
    .rs1_i      (rs1),
    .rs2_i      (rs2),
    .rs1_pend_o (rs1_pend_s),
    .rs2_pend_o (rs2_pend_s)
  );

`ifdef WB_BYPASS_EN
  assign rs1_fwd  = we3_q & (a3_q == rs1);
  assign rs2_fwd  = we3_q & (a3_q == rs2);
  assign fwd_data = di3_q;
  assign rs1_busy = rs1_pend_s & ~rs1_fwd;
  assign rs2_busy = rs2_pend_s & ~rs2_fwd;
`else
  assign rs1_busy = rs1_pend_s;
  assign rs2_busy = rs2_pend_s;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, a reset
// mid-transfer sequence, and randomized traffic against a reference model.
module tb_regfile_wb_arbiter;

  localparam int XLEN = 32;

  logic            clk;
  logic            reset;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            wb0_valid, wb1_valid;
  logic [4:0]      wb0_rd, wb1_rd;
  logic [XLEN-1:0] wb0_data, wb1_data;
  logic            wb0_ready, wb1_ready;
  logic [4:0]      a3;
  logic [XLEN-1:0] di3;
  logic            we3;
  logic [4:0]      rs1, rs2;
  logic            rs1_busy, rs2_busy;
`ifdef WB_BYPASS_EN
  logic            rs1_fwd, rs2_fwd;
  logic [XLEN-1:0] fwd_data;
`endif

  int n_checks = 0;
  int n_err    = 0;

  regfile_wb_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .wb0_valid   (wb0_valid),
    .wb0_rd      (wb0_rd),
    .wb0_data    (wb0_data),
    .wb0_ready   (wb0_ready),
    .wb1_valid   (wb1_valid),
    .wb1_rd      (wb1_rd),
    .wb1_data    (wb1_data),
    .wb1_ready   (wb1_ready),
    .a3          (a3),
    .di3         (di3),
    .we3         (we3),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy)
`ifdef WB_BYPASS_EN
    ,
    .rs1_fwd     (rs1_fwd),
    .rs2_fwd     (rs2_fwd),
    .fwd_data    (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;  logic [4:0] ird;
    logic        v0;  logic [4:0] rd0; logic [31:0] d0;
    logic        v1;  logic [4:0] rd1; logic [31:0] d1;
    logic [4:0]  r1;  logic [4:0] r2;
    logic        er0; logic er1; logic ewe;
    logic [4:0]  ea3; logic [31:0] edi;
    logic        eb1; logic eb2;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(
    input logic iv, input logic [4:0] ird,
    input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
    input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
    input logic [4:0] r1, input logic [4:0] r2,
    input logic er0, input logic er1, input logic ewe,
    input logic [4:0] ea3, input logic [31:0] edi,
    input logic eb1, input logic eb2);
    vec_t v;
    v.iv = iv; v.ird = ird; v.v0 = v0; v.rd0 = rd0; v.d0 = d0;
    v.v1 = v1; v.rd1 = rd1; v.d1 = d1; v.r1 = r1; v.r2 = r2;
    v.er0 = er0; v.er1 = er1; v.ewe = ewe; v.ea3 = ea3; v.edi = edi;
    v.eb1 = eb1; v.eb2 = eb2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    issue_valid = v.iv; issue_rd = v.ird;
    wb0_valid = v.v0; wb0_rd = v.rd0; wb0_data = v.d0;
    wb1_valid = v.v1; wb1_rd = v.rd1; wb1_data = v.d1;
    rs1 = v.r1; rs2 = v.r2;
  endtask

  // Busy expectation given pending state and the write currently on the port.
  function automatic logic exp_busy(input logic pend, input logic [4:0] rs,
                                    input logic wr_we, input logic [4:0] wr_a3);
`ifdef WB_BYPASS_EN
    return (rs != 5'd0) && pend && !(wr_we && wr_a3 == rs);
`else
    return (rs != 5'd0) && pend;
`endif
  endfunction

  task automatic chk_fwd(input string tag, input logic wr_we, input logic [4:0] wr_a3,
                         input logic [31:0] wr_di);
`ifdef WB_BYPASS_EN
    chk({tag, " rs1_fwd"}, 64'(rs1_fwd), 64'(wr_we && wr_a3 == rs1));
    chk({tag, " rs2_fwd"}, 64'(rs2_fwd), 64'(wr_we && wr_a3 == rs2));
    if (wr_we && (wr_a3 == rs1 || wr_a3 == rs2))
      chk({tag, " fwd_data"}, 64'(fwd_data), 64'(wr_di));
`else
    n_checks = n_checks + 0;
`endif
  endtask

  // reference model state
  logic        pend_m[32];
  int          tie_m;
  logic        exp_we;
  logic [4:0]  exp_a3;
  logic [31:0] exp_di;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    string tag;
    logic  b1, b2;
    int    g;
    logic  acc0, acc1;
    logic  [4:0] grd;
    logic  [31:0] gdat;

    //        iv ird  v0 rd0 d0       v1 rd1 d1           r1 r2  er0 er1 ewe ea3 edi          eb1 eb2
    tbl[0]  = mk(1,5'd7, 0,5'd0,32'd0,  0,5'd0,32'd0,        5'd7,5'd5, 0,0,0,5'd0,32'd0,        0,0);
    tbl[1]  = mk(0,5'd0, 1,5'd7,32'd69, 0,5'd0,32'd0,        5'd7,5'd5, 1,0,0,5'd0,32'd0,        1,0);
    tbl[2]  = mk(0,5'd0, 0,5'd0,32'd0,  0,5'd0,32'd0,        5'd7,5'd5, 0,0,1,5'd7,32'd69,       1,0);
    tbl[3]  = mk(0,5'd0, 0,5'd0,32'd0,  0,5'd0,32'd0,        5'd7,5'd5, 0,0,0,5'd7,32'd69,       0,0);
    tbl[4]  = mk(1,5'd0, 0,5'd0,32'd0,  1,5'd0,32'hDEAD,     5'd5,5'd0, 0,1,0,5'd7,32'd69,       0,0);
    tbl[5]  = mk(0,5'd0, 0,5'd0,32'd0,  0,5'd0,32'd0,        5'd5,5'd0, 0,0,0,5'd0,32'hDEAD,     0,0);
    tbl[6]  = mk(0,5'd0, 1,5'd1,32'h11, 1,5'd2,32'h22,       5'd5,5'd5, 1,0,0,5'd0,32'hDEAD,     0,0);
    tbl[7]  = mk(0,5'd0, 1,5'd1,32'h11, 1,5'd2,32'h22,       5'd5,5'd5, 0,1,1,5'd1,32'h11,       0,0);
    tbl[8]  = mk(0,5'd0, 1,5'd1,32'h11, 1,5'd2,32'h22,       5'd5,5'd5, 1,0,1,5'd2,32'h22,       0,0);
    tbl[9]  = mk(0,5'd0, 1,5'd1,32'h11, 1,5'd2,32'h22,       5'd5,5'd5, 0,1,1,5'd1,32'h11,       0,0);
    tbl[10] = mk(0,5'd0, 0,5'd0,32'd0,  0,5'd0,32'd0,        5'd5,5'd5, 0,0,1,5'd2,32'h22,       0,0);
    tbl[11] = mk(1,5'd3, 0,5'd0,32'd0,  0,5'd0,32'd0,        5'd3,5'd5, 0,0,0,5'd2,32'h22,       0,0);
    tbl[12] = mk(0,5'd0, 1,5'd3,32'h33, 0,5'd0,32'd0,        5'd3,5'd5, 1,0,0,5'd2,32'h22,       1,0);
    tbl[13] = mk(1,5'd3, 0,5'd0,32'd0,  0,5'd0,32'd0,        5'd3,5'd5, 0,0,1,5'd3,32'h33,       1,0);
    tbl[14] = mk(0,5'd0, 0,5'd0,32'd0,  0,5'd0,32'd0,        5'd3,5'd5, 0,0,0,5'd3,32'h33,       1,0);
    tbl[15] = mk(0,5'd0, 1,5'd3,32'h44, 0,5'd0,32'd0,        5'd3,5'd5, 1,0,0,5'd3,32'h33,       1,0);
    tbl[16] = mk(0,5'd0, 0,5'd0,32'd0,  0,5'd0,32'd0,        5'd3,5'd5, 0,0,1,5'd3,32'h44,       1,0);
    tbl[17] = mk(0,5'd0, 0,5'd0,32'd0,  0,5'd0,32'd0,        5'd3,5'd5, 0,0,0,5'd3,32'h44,       0,0);

    // reset with both requesters asking: no grants, write port cleared
    reset = 1'b1; issue_valid = 1'b0; issue_rd = 5'd0;
    wb0_valid = 1'b1; wb0_rd = 5'd1; wb0_data = 32'h1;
    wb1_valid = 1'b1; wb1_rd = 5'd2; wb1_data = 32'h2;
    rs1 = 5'd5; rs2 = 5'd6;
    @(negedge clk); @(negedge clk); #1;
    chk("reset wb0_ready", 64'(wb0_ready), 64'd0);
    chk("reset wb1_ready", 64'(wb1_ready), 64'd0);
    chk("reset we3", 64'(we3), 64'd0);
    chk("reset a3", 64'(a3), 64'd0);
    chk("reset di3", 64'(di3), 64'd0);
    chk("reset rs1_busy", 64'(rs1_busy), 64'd0);
    reset = 1'b0; wb0_valid = 1'b0; wb1_valid = 1'b0;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      tag = $sformatf("row%0d", i);
      b1 = tbl[i].eb1 && exp_busy(1'b1, tbl[i].r1, tbl[i].ewe, tbl[i].ea3);
      b2 = tbl[i].eb2 && exp_busy(1'b1, tbl[i].r2, tbl[i].ewe, tbl[i].ea3);
      chk({tag, " wb0_ready"}, 64'(wb0_ready), 64'(tbl[i].er0));
      chk({tag, " wb1_ready"}, 64'(wb1_ready), 64'(tbl[i].er1));
      chk({tag, " we3"}, 64'(we3), 64'(tbl[i].ewe));
      chk({tag, " a3"}, 64'(a3), 64'(tbl[i].ea3));
      chk({tag, " di3"}, 64'(di3), 64'(tbl[i].edi));
      chk({tag, " rs1_busy"}, 64'(rs1_busy), 64'(b1));
      chk({tag, " rs2_busy"}, 64'(rs2_busy), 64'(b2));
      chk_fwd(tag, tbl[i].ewe, tbl[i].ea3, tbl[i].edi);
    end

    // reset asserted while a write to x9 is on the port
    @(negedge clk);
    drive(mk(1,5'd9, 0,5'd0,32'd0, 0,5'd0,32'd0, 5'd0,5'd0, 0,0,0,5'd0,32'd0, 0,0));
    @(negedge clk);
    drive(mk(1,5'd10, 1,5'd9,32'd42, 0,5'd0,32'd0, 5'd0,5'd0, 0,0,0,5'd0,32'd0, 0,0));
    #1;
    chk("mid wb0_ready", 64'(wb0_ready), 64'd1);
    @(negedge clk);
    drive(mk(0,5'd0, 0,5'd0,32'd0, 1,5'd4,32'd5, 5'd10,5'd9, 0,0,0,5'd0,32'd0, 0,0));
    reset = 1'b1;
    #1;
    chk("mid we3", 64'(we3), 64'd1);
    chk("mid a3", 64'(a3), 64'd9);
    chk("mid di3", 64'(di3), 64'd42);
    chk("mid wb1_ready in reset", 64'(wb1_ready), 64'd0);
    chk("mid rs1_busy", 64'(rs1_busy), 64'(exp_busy(1'b1, 5'd10, 1'b1, 5'd9)));
    chk("mid rs2_busy", 64'(rs2_busy), 64'(exp_busy(1'b1, 5'd9, 1'b1, 5'd9)));
    chk_fwd("mid", 1'b1, 5'd9, 32'd42);
    @(negedge clk);
    reset = 1'b0; wb1_valid = 1'b0;
    #1;
    chk("post-reset we3", 64'(we3), 64'd0);
    chk("post-reset a3", 64'(a3), 64'd0);
    chk("post-reset di3", 64'(di3), 64'd0);
    chk("post-reset rs1_busy", 64'(rs1_busy), 64'd0);
    chk("post-reset rs2_busy", 64'(rs2_busy), 64'd0);

    // random traffic against the reference model, starting from reset state
    for (int r = 0; r < 32; r++) pend_m[r] = 1'b0;
    tie_m = 0; exp_we = 1'b0; exp_a3 = 5'd0; exp_di = 32'd0;
    acc0 = 1'b0; acc1 = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (acc0) wb0_valid = 1'b0;
      if (acc1) wb1_valid = 1'b0;
      if (!wb0_valid && $urandom_range(0, 1) == 1) begin
        wb0_valid = 1'b1; wb0_rd = 5'($urandom_range(0, 7)); wb0_data = $urandom;
      end
      if (!wb1_valid && $urandom_range(0, 1) == 1) begin
        wb1_valid = 1'b1; wb1_rd = 5'($urandom_range(0, 7)); wb1_data = $urandom;
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 7));
      rs1         = 5'($urandom_range(0, 7));
      rs2         = 5'($urandom_range(0, 7));
      #1;
      if (wb0_valid && wb1_valid) g = tie_m;
      else if (wb0_valid)         g = 0;
      else if (wb1_valid)         g = 1;
      else                        g = -1;
      tag = $sformatf("rand%0d", c);
      chk({tag, " wb0_ready"}, 64'(wb0_ready), 64'(g == 0));
      chk({tag, " wb1_ready"}, 64'(wb1_ready), 64'(g == 1));
      chk({tag, " we3"}, 64'(we3), 64'(exp_we));
      chk({tag, " a3"}, 64'(a3), 64'(exp_a3));
      chk({tag, " di3"}, 64'(di3), 64'(exp_di));
      chk({tag, " rs1_busy"}, 64'(rs1_busy), 64'(exp_busy(pend_m[rs1], rs1, exp_we, exp_a3)));
      chk({tag, " rs2_busy"}, 64'(rs2_busy), 64'(exp_busy(pend_m[rs2], rs2, exp_we, exp_a3)));
      chk_fwd(tag, exp_we, exp_a3, exp_di);
      // model the coming rising edge
      if (exp_we) pend_m[exp_a3] = 1'b0;
      if (issue_valid && issue_rd != 5'd0) pend_m[issue_rd] = 1'b1;
      acc0 = (g == 0);
      acc1 = (g == 1);
      if (g >= 0) begin
        grd  = (g == 0) ? wb0_rd : wb1_rd;
        gdat = (g == 0) ? wb0_data : wb1_data;
        exp_a3 = grd;
        exp_di = gdat;
        exp_we = (grd != 5'd0);
        tie_m  = 1 - g;
      end else begin
        exp_we = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
- REQ-001 The block SHALL have parameter XLEN, default 32, meaning register data width.
- REQ-002 The block SHALL have parameter REG_CNT, default 32, meaning architectural register count; addresses are $clog2(REG_CNT) bits (5 at default).
- REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
- REQ-004 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
- REQ-005 Port reset: input, 1 bit, synchronous active-high reset.
- REQ-006 Ports issue_valid / issue_rd: input, 1 / 5 bits, an instruction is issued that will write issue_rd.
- REQ-007 Ports wbN_valid / wbN_rd / wbN_data, N=0,1: input, 1 / 5 / XLEN bits, write-back request from requester N (0 = ALU, 1 = load unit).
- REQ-008 Port wbN_ready, N=0,1: output, 1 bit, request N accepted this cycle.
- REQ-009 Ports a3 / di3 / we3: output, 5 / XLEN / 1 bits, drive the register-file write port.
- REQ-010 Ports rs1 / rs2: input, 5 bits each, source registers to check.
- REQ-011 Ports rs1_busy / rs2_busy: output, 1 bit each, source has an uncommitted pending write.

Function
- REQ-012 A handshake on requester N SHALL occur on a rising edge where wbN_valid and wbN_ready are both 1; requesters SHALL hold rd/data stable until accepted.
- REQ-013 At most one wbN_ready SHALL be 1 per cycle; wbN_ready is combinational from valids and the priority state.
- REQ-014 Arbitration SHALL be round-robin, two states: PRIO0 (requester 0 wins ties) and PRIO1 (requester 1 wins ties); after a grant to N the state moves to PRIO(1-N); with no grant the state is unchanged.
- REQ-015 A lone valid requester SHALL be granted regardless of state.
- REQ-016 Write-port outputs SHALL be registered: a3/di3/we3 reflect the accepted request exactly one cycle after the handshake edge; we3 is 1 for exactly one cycle per accepted write.
- REQ-017 Requests with rd = 0 SHALL be accepted normally but SHALL produce we3 = 0; a3/di3 still update.
- REQ-018 A REG_CNT-bit pending scoreboard SHALL set bit issue_rd on an edge with issue_valid = 1 and issue_rd != 0; issue to x0 is ignored.
- REQ-019 A pending bit SHALL clear on the edge that ends its we3 = 1 cycle (the register-file write edge).
- REQ-020 Simultaneous set and clear of the same bit SHALL leave it set.
- REQ-021 rsN_busy SHALL be combinational: pending[rsN]; rs = 0 always reads 0.

Reset
- REQ-022 While reset = 1 at an edge: scoreboard cleared, state = PRIO0, a3 = 0, di3 = 0, we3 = 0.
- REQ-023 While reset is 1, wb0_ready and wb1_ready SHALL be 0; an in-flight write registered before reset is dropped (we3 = 0 next cycle).

Configuration
- REQ-024 Macro WB_BYPASS_EN SHALL, when defined, add outputs rs1_fwd / rs2_fwd (1 bit) and fwd_data (XLEN bits): during a we3 = 1 cycle with a3 == rsN, rsN_fwd = 1, rsN_busy = 0, fwd_data = di3.
- REQ-025 Without WB_BYPASS_EN these ports SHALL not exist, and rsN_busy stays 1 through the we3 cycle.

Structure
- REQ-026 XLEN default, register address width, and the PRIO0/PRIO1 state enum SHALL live in the shared core package.
- REQ-027 The scoreboard SHALL be a sub-module, regfile_scoreboard (set port, clear port, two lookup ports); the arbiter and output registers stay in the top module.

Verification
- REQ-028 Reset then idle: we3 = 0, both readies 0 during reset, rs1_busy = 0 for rs1 = 5.
- REQ-029 Issue rd = 7; one cycle later wb0 writes rd = 7, data = 69: we3 = 1, a3 = 7, di3 = 69 on the cycle after the handshake; rs1 = 7 reads busy until the edge ending that cycle, then 0.
- REQ-030 Both requesters valid for 4 cycles (wb0 rd = 1, wb1 rd = 2), starting in PRIO0: grants alternate 0,1,0,1.
- REQ-031 wb1 writes rd = 0, data = 0xDEAD: wb1_ready = 1, we3 stays 0; issue to x0 leaves rs2_busy = 0 for rs2 = 0.
- REQ-032 Issue rd = 3 on the same edge that ends the we3 = 1 cycle of a3 = 3: rs1 = 3 remains busy.
- REQ-033 With WB_BYPASS_EN: during we3 = 1, a3 = 9, di3 = 42, rs2 = 9: rs2_fwd = 1, fwd_data = 42, rs2_busy = 0. Reset asserted mid-transfer: we3 = 0 next cycle, scoreboard empty.
